matrix_result_reader: RTL and testbench

- Downstream consumer of the coprocessor's write-back into the 200-bit matrix memory.
- On a start pulse (driven from the coprocessor DONE), reads one 200-bit result word from memory at a given address.
- Unpacks the word into 8-bit matrix elements and streams them out in row-major order over a valid/ready handshake, for display or host readback.
- The memory port is shared: this block drives the address only while busy, and never asserts a write.

---
 rtl/matrix_result_reader.sv | 181 ++++++++++++++++++
 tb/tb_matrix_result_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_reader.sv
// matrix_result_reader: fetches one packed result word from the shared matrix
// memory after a start request. It then streams the NxN elements in row-major
// order over a valid/ready handshake.
// Optional build macro RESULT_CHECKSUM_EN adds a 16-bit running sum of the
// streamed elements. Without it, checksum is tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; mem_address holds its last value
// S_ADDR   | base address presented to memory for one cycle
// S_WAIT   | down-counter covers the remaining MEM_LAT-1 read cycles
// S_LOAD   | memory word captured; first element prepared
// S_STREAM | elements presented; one transfer per valid&&ready cycle
// S_DONE   | one-cycle done pulse, then back to idle
module matrix_result_reader #(
    parameter int MEM_LAT = 2,
    parameter int DIM_MAX = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [7:0]                       base_addr,
    input  logic [2:0]                       mat_size,
    output logic [7:0]                       mem_address,
    input  logic [DIM_MAX*DIM_MAX*8-1:0]     mem_data,
    output logic [7:0]                       elem_data,
    output logic [2:0]                       elem_row,
    output logic [2:0]                       elem_col,
    output logic                             elem_valid,
    output logic                             elem_last,
    input  logic                             elem_ready,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      checksum
);

    localparam int          WORD_W    = DIM_MAX * DIM_MAX * 8;
    localparam int          OFS_W     = $clog2(WORD_W);
    localparam logic [2:0]  DIM_N     = 3'(DIM_MAX);
    // WAIT exits when the counter reaches zero, so it is loaded with MEM_LAT-2
    localparam logic [1:0]  WAIT_INIT = 2'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state;
    logic [1:0]          wait_cnt;
    logic [2:0]          n_q;
    logic [2:0]          n_last;
    logic [2:0]          size_clamped;
    logic [2:0]          col_next;
    logic [2:0]          row_next;
    logic [OFS_W-1:0]    elem_ofs;
    logic [7:0]          elem_next;
    logic [WORD_W-1:0]   word_q;
    logic                transfer;

    assign transfer = elem_valid & elem_ready;
    assign n_last   = n_q - 3'd1;

    // Clamp the requested dimension into the supported 2..DIM_MAX range
    always_comb begin
        size_clamped = mat_size;
        if (mat_size < 3'd2) begin
            size_clamped = 3'd2;
        end else if (mat_size > DIM_N) begin
            size_clamped = DIM_N;
        end
    end

    // Next row/column in row-major order and the element it selects from the
    // captured word (packing stride is always DIM_MAX, whatever N is)
    always_comb begin
        col_next = elem_col + 3'd1;
        row_next = elem_row;
        if (elem_col == n_last) begin
            col_next = 3'd0;
            row_next = elem_row + 3'd1;
        end
        elem_ofs  = OFS_W'((32'(row_next) * DIM_MAX + 32'(col_next)) * 8);
        elem_next = word_q[elem_ofs +: 8];
    end

    // Sequencer: fetch, capture, then stream elements with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 2'd0;
            n_q         <= 3'd2;
            word_q      <= '0;
            mem_address <= 8'd0;
            elem_data   <= 8'd0;
            elem_row    <= 3'd0;
            elem_col    <= 3'd0;
            elem_valid  <= 1'b0;
            elem_last   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_address <= base_addr;
                        n_q         <= size_clamped;
                        busy        <= 1'b1;
                        state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (MEM_LAT > 1) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end else begin
                        state    <= S_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_LOAD: begin
                    // Private copy so later memory writes cannot disturb the stream
                    word_q     <= mem_data;
                    elem_data  <= mem_data[7:0];
                    elem_row   <= 3'd0;
                    elem_col   <= 3'd0;
                    elem_last  <= 1'b0;
                    elem_valid <= 1'b1;
                    state      <= S_STREAM;
                end
                S_STREAM: begin
                    if (transfer) begin
                        if (elem_last) begin
                            elem_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            elem_col  <= col_next;
                            elem_row  <= row_next;
                            elem_data <= elem_next;
                            elem_last <= (row_next == n_last) && (col_next == n_last);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // Running sum of transferred elements, cleared when a new read is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= 16'd0;
        end else if (state == S_IDLE && start) begin
            checksum <= 16'd0;
        end else if (transfer) begin
            checksum <= checksum + {8'd0, elem_data};
        end
    end
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed self-checking bench for matrix_result_reader with a MEM_LAT-deep
// read pipeline modelling the shared memory.
module tb_matrix_result_reader;

    localparam int MEM_LAT = 2;
    localparam int DIM_MAX = 5;
    localparam int WORD_W  = DIM_MAX * DIM_MAX * 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        base_addr = 8'd0;
    logic [2:0]        mat_size = 3'd0;
    logic [7:0]        mem_address;
    logic [WORD_W-1:0] mem_data;
    logic [7:0]        elem_data;
    logic [2:0]        elem_row;
    logic [2:0]        elem_col;
    logic              elem_valid;
    logic              elem_last;
    logic              elem_ready = 1'b1;
    logic              busy;
    logic              done;
    logic [15:0]       checksum;

    logic [WORD_W-1:0] mem  [256];
    logic [WORD_W-1:0] pipe [MEM_LAT];
    logic [WORD_W-1:0] word10;
    logic [WORD_W-1:0] word20;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q_data [$];
    logic [2:0] q_row  [$];
    logic [2:0] q_col  [$];
    logic       q_last [$];
    int          lat;
    int          done_k;
    int          done_cnt;
    int          last_k;
    int          addr_bad;
    logic [15:0] done_csum;
    logic        done_busy;

    matrix_result_reader #(.MEM_LAT(MEM_LAT), .DIM_MAX(DIM_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .mat_size   (mat_size),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .elem_data  (elem_data),
        .elem_row   (elem_row),
        .elem_col   (elem_col),
        .elem_valid (elem_valid),
        .elem_last  (elem_last),
        .elem_ready (elem_ready),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Synchronous read memory with MEM_LAT cycles of latency
    always @(posedge clk) begin
        pipe[0] <= mem[mem_address];
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data = pipe[MEM_LAT-1];

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] a, input logic [2:0] s);
        @(negedge clk);
        base_addr = a;
        mat_size  = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start busy", 32'(busy), 32'd1);
        check("start mem_address", 32'(mem_address), 32'(a));
    endtask

    // Runs one stream starting at the negedge just after the start edge (k=1).
    task automatic collect(input int max_cyc, input logic [15:0] pat, input int pat_len,
                           input int inject_k, input bit inject_done, input int stop_after,
                           input bit clobber, input logic [7:0] exp_addr);
        int vk;
        bit seen;
        bit hold;
        logic [7:0] pd;
        logic [2:0] pr;
        logic [2:0] pc;
        logic       pl;
        q_data.delete(); q_row.delete(); q_col.delete(); q_last.delete();
        lat = -1; done_k = -1; done_cnt = 0; last_k = -1; addr_bad = 0;
        done_csum = 16'hFFFF; done_busy = 1'b1;
        vk = 0; seen = 0; hold = 0; pd = 0; pr = 0; pc = 0; pl = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (stop_after > 0 && q_data.size() >= stop_after) break;
            if (done_k > 0 && k > done_k + 2) break;
            if (hold) begin
                check("hold valid", 32'(elem_valid), 32'd1);
                check("hold data", 32'(elem_data), 32'(pd));
                check("hold row", 32'(elem_row), 32'(pr));
                check("hold col", 32'(elem_col), 32'(pc));
                check("hold last", 32'(elem_last), 32'(pl));
            end
            if (busy && mem_address !== exp_addr) addr_bad++;
            if (!seen && elem_valid) begin
                seen = 1;
                lat  = k;
            end
            elem_ready = (seen && vk < pat_len) ? pat[vk] : 1'b1;
            if (seen) vk++;
            hold = elem_valid && !elem_ready;
            pd = elem_data; pr = elem_row; pc = elem_col; pl = elem_last;
            if (elem_valid && elem_ready) begin
                q_data.push_back(elem_data);
                q_row.push_back(elem_row);
                q_col.push_back(elem_col);
                q_last.push_back(elem_last);
                last_k = k;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k    = k;
                    done_csum = checksum;
                    done_busy = busy;
                end
            end
            if (k == inject_k || (inject_done && done)) begin
                start     = 1'b1;
                base_addr = 8'h20;
                mat_size  = 3'd4;
            end else begin
                start = 1'b0;
            end
            if (clobber && lat == k) mem[8'h10] = '0;
            @(negedge clk);
        end
        start      = 1'b0;
        elem_ready = 1'b1;
    endtask

    task automatic verify_stream(input string tag, input int n);
        int r;
        int c;
        logic [15:0] sum;
        logic [15:0] exp_csum;
        sum = 16'd0;
        check({tag, " count"}, 32'(q_data.size()), 32'(n * n));
        for (int k = 0; k < n * n && k < q_data.size(); k++) begin
            r = k / n;
            c = k % n;
            check($sformatf("%s data[%0d]", tag, k), 32'(q_data[k]), 32'(r * DIM_MAX + c + 1));
            check($sformatf("%s row[%0d]", tag, k), 32'(q_row[k]), 32'(r));
            check($sformatf("%s col[%0d]", tag, k), 32'(q_col[k]), 32'(c));
            check($sformatf("%s last[%0d]", tag, k), 32'(q_last[k]), 32'(k == n * n - 1));
            sum = sum + 16'(r * DIM_MAX + c + 1);
        end
`ifdef RESULT_CHECKSUM_EN
        exp_csum = sum;
`else
        exp_csum = 16'd0;
`endif
        check({tag, " latency"}, 32'(lat), 32'(MEM_LAT + 2));
        check({tag, " done timing"}, 32'(done_k), 32'(last_k + 1));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " busy at done"}, 32'(done_busy), 32'd0);
        check({tag, " checksum"}, 32'(done_csum), 32'(exp_csum));
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle valid"}, 32'(elem_valid), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        for (int j = 0; j < DIM_MAX * DIM_MAX; j++) begin
            word10[j*8 +: 8] = 8'(j + 1);
            word20[j*8 +: 8] = 8'(8'hA0 + j);
        end
        mem[8'h10] = word10;
        mem[8'h20] = word20;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst mem_address", 32'(mem_address), 32'd0);
        check("rst elem_data", 32'(elem_data), 32'd0);
        check("rst elem_row", 32'(elem_row), 32'd0);
        check("rst elem_col", 32'(elem_col), 32'd0);
        check("rst elem_valid", 32'(elem_valid), 32'd0);
        check("rst elem_last", 32'(elem_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full 5x5 stream with ready held high
        do_start(8'h10, 3'd5);
        collect(80, 16'h0, 0, -1, 0, 0, 0, 8'h10);
        verify_stream("n5", 5);
        check("n5 mem_address held", 32'(mem_address), 32'h10);

        // 3x3 subset; memory word overwritten mid-stream; start on the done cycle
        do_start(8'h10, 3'd3);
        collect(80, 16'h0, 0, -1, 1, 0, 1, 8'h10);
        mem[8'h10] = word10;
        verify_stream("n3", 3);

        // 2x2 with backpressure pattern 0,0,1,0,1,1 from the first valid cycle
        do_start(8'h10, 3'd2);
        collect(80, 16'b110100, 6, -1, 0, 0, 0, 8'h10);
        verify_stream("bp", 2);

        // Clamping below and above the supported range
        do_start(8'h10, 3'd0);
        collect(80, 16'h0, 0, -1, 0, 0, 0, 8'h10);
        verify_stream("clamp0", 2);
        do_start(8'h10, 3'd7);
        collect(80, 16'h0, 0, -1, 0, 0, 0, 8'h10);
        verify_stream("clamp7", 5);

        // Second start mid-stream with another address must be ignored
        do_start(8'h10, 3'd5);
        collect(80, 16'h0, 0, 10, 0, 0, 0, 8'h10);
        verify_stream("busystart", 5);
        check("busystart addr moves", 32'(addr_bad), 32'd0);
        check("busystart mem_address", 32'(mem_address), 32'h10);

        // Reset after three transfers aborts the stream on the next edge
        do_start(8'h10, 3'd5);
        collect(80, 16'h0, 0, -1, 0, 3, 0, 8'h10);
        check("midrst transfers", 32'(q_data.size()), 32'd3);
        check("midrst third elem", 32'(q_data[2]), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("midrst valid", 32'(elem_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst no late done", 32'(done), 32'd0);
        do_start(8'h10, 3'd5);
        collect(80, 16'h0, 0, -1, 0, 0, 0, 8'h10);
        verify_stream("afterrst", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
